// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue handshake bundle (PC in, imem request/response, decode out)
interface fetch_queue_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   pc_valid;
  logic                   pc_ready;
  logic [PC_WIDTH-1:0]    pc_in;
  logic                   flush;
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic                   out_err;

  // Environment side: PC generator, branch resolution, instruction memory and decode
  modport master (
    output pc_valid, pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  pc_ready, imem_req, imem_addr, out_valid, out_pc, out_instr, out_err
  );

  // Fetch queue side
  modport slave (
    input  pc_valid, pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output pc_ready, imem_req, imem_addr, out_valid, out_pc, out_instr, out_err
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue; optional FETCH_MISALIGN_CHECK_EN
module fetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Per-slot storage
  logic [PC_WIDTH-1:0]    slot_pc_q    [DEPTH];
  logic [PC_WIDTH-1:0]    slot_pc_d    [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr_d [DEPTH];
  logic [DEPTH-1:0]       slot_filled_q;
  logic [DEPTH-1:0]       slot_filled_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);
  logic [DEPTH-1:0]       slot_err_q;
  logic [DEPTH-1:0]       slot_err_d;
  logic [PW-1:0]          scan_idx;
  logic [PW-1:0]          scan_off;
  logic                   scan_hit;
`endif

  // Pointers and counters; pend tracks every granted read not yet answered,
  // including the ones already marked for discard
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] pend_q, pend_d;

  logic          misaligned;
  logic          space;
  logic          accept;
  logic          issue;
  logic          pop;
  logic [PW-1:0] fill_idx;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (bus.pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign space = ({1'b0, count_q} + {1'b0, discard_q}) < (CW+1)'(DEPTH);

  // Request never looks at pc_ready, so memory can grant combinationally
  assign bus.imem_req  = bus.pc_valid & space & ~bus.flush & ~rst & ~misaligned;
  assign bus.imem_addr = bus.pc_in;
  assign bus.pc_ready  = space & ~bus.flush & ~rst & (bus.imem_gnt | misaligned);

  assign accept = bus.pc_valid & bus.pc_ready;
  assign issue  = bus.imem_req & bus.imem_gnt;

  assign bus.out_valid = slot_filled_q[head_q] & ~bus.flush & ~rst;
  assign bus.out_pc    = slot_pc_q[head_q];
  assign bus.out_instr = slot_instr_q[head_q];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.out_err   = slot_err_q[head_q];
`else
  assign bus.out_err   = 1'b0;
`endif

  assign pop = bus.out_valid & bus.out_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Response target: first allocated, still-empty slot from fill, skipping pre-filled misaligned slots
  always_comb begin
    fill_idx = fill_q;
    scan_hit = 1'b0;
    scan_idx = fill_q;
    scan_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = fill_q + PW'(i);
      scan_off = scan_idx - head_q;
      if (!scan_hit && !slot_filled_q[scan_idx] && ({1'b0, scan_off} < count_q)) begin
        fill_idx = scan_idx;
        scan_hit = 1'b1;
      end
    end
  end
`else
  // Without the misalign path every slot waits for memory, so fill is the target
  always_comb begin
    fill_idx = fill_q;
  end
`endif

  // Next-state for slots, pointers and counters: allocate, fill and pop may coincide
  always_comb begin
    slot_pc_d     = slot_pc_q;
    slot_instr_d  = slot_instr_q;
    slot_filled_d = slot_filled_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    slot_err_d    = slot_err_q;
`endif
    head_d    = head_q;
    fill_d    = fill_q;
    alloc_d   = alloc_q;
    count_d   = count_q;
    discard_d = discard_q;
    pend_d    = pend_q + CW'(issue) - CW'(bus.imem_rvalid);

    if (bus.flush) begin
      // Everything outstanding becomes a discard; a response arriving now is already consumed
      head_d        = '0;
      fill_d        = '0;
      alloc_d       = '0;
      count_d       = '0;
      slot_filled_d = '0;
      discard_d     = pend_q - CW'(bus.imem_rvalid);
    end else begin
      if (accept) begin
        slot_pc_d[alloc_q]     = bus.pc_in;
        slot_filled_d[alloc_q] = misaligned;
`ifdef FETCH_MISALIGN_CHECK_EN
        slot_err_d[alloc_q]    = misaligned;
        if (misaligned) begin
          slot_instr_d[alloc_q] = NOP_INSTR;
        end
`endif
        alloc_d = alloc_q + PW'(1);
      end
      if (bus.imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          slot_instr_d[fill_idx]  = bus.imem_rdata;
          slot_filled_d[fill_idx] = 1'b1;
          fill_d                  = fill_idx + PW'(1);
        end
      end
      if (pop) begin
        slot_filled_d[head_q] = 1'b0;
        head_d                = head_q + PW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
      slot_filled_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      slot_err_q    <= '0;
`endif
      head_q    <= '0;
      fill_q    <= '0;
      alloc_q   <= '0;
      count_q   <= '0;
      discard_q <= '0;
      pend_q    <= '0;
    end else begin
      slot_pc_q     <= slot_pc_d;
      slot_instr_q  <= slot_instr_d;
      slot_filled_q <= slot_filled_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      slot_err_q    <= slot_err_d;
`endif
      head_q    <= head_d;
      fill_q    <= fill_d;
      alloc_q   <= alloc_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      pend_q    <= pend_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   tb_pend;

  fetch_queue_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.pc_valid    = 1'b0;
    bus.pc_in       = '0;
    bus.flush       = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.out_ready   = 1'b0;
  endtask

  // Memory protocol: a response needs a previously granted, unanswered request
  always @(negedge clk) begin
    if (rst) begin
      tb_pend = 0;
    end else begin
      if (bus.imem_rvalid) check("rvalid_has_request", 64'(tb_pend != 0), 64'd1);
      tb_pend = tb_pend + ((bus.imem_req && bus.imem_gnt) ? 1 : 0) - (bus.imem_rvalid ? 1 : 0);
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    tb_pend  = 0;
    idle();
    rst = 1'b1;

    // Reset: offered PC with grant must be ignored
    bus.pc_valid = 1'b1;
    bus.imem_gnt = 1'b1;
    tick();
    mid();
    check("rst_pc_ready", bus.pc_ready, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_out_valid", bus.out_valid, 0);
    tick();
    rst = 1'b0;
    idle();
    mid();
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out_pc", bus.out_pc, 0);
    check("post_rst_out_instr", bus.out_instr, 0);
    check("post_rst_out_err", bus.out_err, 0);
    tick();

    // Minimum latency and throughput
    bus.pc_valid = 1'b1; bus.pc_in = 32'h0; bus.imem_gnt = 1'b1;
    mid();
    check("t1_req", bus.imem_req, 1);
    check("t1_addr", bus.imem_addr, 32'h0);
    check("t1_ready", bus.pc_ready, 1);
    tick();
    bus.pc_in = 32'h4; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093; bus.out_ready = 1'b1;
    mid();
    check("t1_valid_T1", bus.out_valid, 0);
    tick();
    bus.pc_in = 32'h8; bus.imem_rdata = 32'h00A0_0113;
    mid();
    check("t1_valid_T2", bus.out_valid, 1);
    check("t1_pc0", bus.out_pc, 32'h0);
    check("t1_instr0", bus.out_instr, 32'h0050_0093);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rdata = 32'h0020_81B3;
    mid();
    check("t1_valid1", bus.out_valid, 1);
    check("t1_pc1", bus.out_pc, 32'h4);
    check("t1_instr1", bus.out_instr, 32'h00A0_0113);
    tick();
    bus.imem_rvalid = 1'b0;
    mid();
    check("t1_valid2", bus.out_valid, 1);
    check("t1_pc2", bus.out_pc, 32'h8);
    check("t1_instr2", bus.out_instr, 32'h0020_81B3);
    tick();
    idle();
    mid();
    check("t1_empty", bus.out_valid, 0);
    tick();

    // Back-pressure: four PCs fill the queue, the fifth is refused
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.pc_valid    = 1'b1;
      bus.pc_in       = 32'h10 + 32'(4 * i);
      bus.imem_rvalid = (i > 0);
      bus.imem_rdata  = (i > 0) ? 32'hA000_0000 + 32'(i - 1) : 32'h0;
      mid();
      if (i == 4) begin
        check("t2_full_ready", bus.pc_ready, 0);
        check("t2_full_req", bus.imem_req, 0);
      end else begin
        check("t2_acc_ready", bus.pc_ready, 1);
      end
      tick();
    end
    bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("t2_pop_ready", bus.pc_ready, 0);
    check("t2_pop_pc", bus.out_pc, 32'h10);
    check("t2_pop_instr", bus.out_instr, 32'hA000_0000);
    tick();
    bus.out_ready = 1'b0;
    mid();
    check("t2_after_pop_ready", bus.pc_ready, 1);
    tick();
    bus.pc_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0004; bus.out_ready = 1'b1;
    mid();
    check("t2_drain_pc", bus.out_pc, 32'h14);
    check("t2_drain_instr", bus.out_instr, 32'hA000_0001);
    tick();
    bus.imem_rvalid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      mid();
      check("t2_drain_pc", bus.out_pc, 32'h18 + 32'(4 * j));
      check("t2_drain_instr", bus.out_instr, 32'hA000_0002 + 32'(j));
      tick();
    end
    idle();
    mid();
    check("t2_empty", bus.out_valid, 0);
    tick();

    // Grant stall: request held stable, accepted exactly once
    bus.pc_valid = 1'b1; bus.pc_in = 32'h20;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t4_stall_ready", bus.pc_ready, 0);
      check("t4_stall_req", bus.imem_req, 1);
      check("t4_stall_addr", bus.imem_addr, 32'h20);
      tick();
    end
    bus.imem_gnt = 1'b1;
    mid();
    check("t4_gnt_ready", bus.pc_ready, 1);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_1111;
    tick();
    bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("t4_out_pc", bus.out_pc, 32'h20);
    check("t4_out_instr", bus.out_instr, 32'h1111_1111);
    tick();
    bus.out_ready = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 32'h40; bus.imem_gnt = 1'b1;
    mid();
    check("t4_single_accept", bus.out_valid, 0);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222;
    tick();
    bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("t4_next_pc", bus.out_pc, 32'h40);
    check("t4_next_instr", bus.out_instr, 32'h2222_2222);
    tick();
    idle();

    // Flush with two reads outstanding
    bus.pc_valid = 1'b1; bus.pc_in = 32'h30; bus.imem_gnt = 1'b1;
    tick();
    bus.pc_in = 32'h34;
    tick();
    bus.flush = 1'b1;
    mid();
    check("t3_flush_ready", bus.pc_ready, 0);
    check("t3_flush_req", bus.imem_req, 0);
    tick();
    bus.flush = 1'b0; bus.pc_in = 32'h100; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    mid();
    check("t3_post_flush_ready", bus.pc_ready, 1);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rdata = 32'hBAD0_BAD0;
    mid();
    check("t3_drop_valid", bus.out_valid, 0);
    tick();
    bus.imem_rdata = 32'h0000_0073;
    mid();
    check("t3_drop2_valid", bus.out_valid, 0);
    tick();
    bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("t3_valid", bus.out_valid, 1);
    check("t3_pc", bus.out_pc, 32'h100);
    check("t3_instr", bus.out_instr, 32'h0000_0073);
    tick();
    idle();

    // Push and pop together at count=DEPTH-1, then flush with a response in the same cycle
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pc_valid    = (i < 3);
      bus.pc_in       = 32'h200 + 32'(4 * i);
      bus.imem_rvalid = (i > 0);
      bus.imem_rdata  = 32'hB000_0000 + 32'(i);
      tick();
    end
    bus.imem_rvalid = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 32'h20C; bus.out_ready = 1'b1;
    mid();
    check("t6_pushpop_ready", bus.pc_ready, 1);
    check("t6_pushpop_pc", bus.out_pc, 32'h200);
    tick();
    bus.out_ready = 1'b0; bus.pc_in = 32'h210;
    mid();
    check("t6_count_held_ready", bus.pc_ready, 1);
    tick();
    bus.pc_in = 32'h214;
    mid();
    check("t6_full_ready", bus.pc_ready, 0);
    check("t6_head_pc", bus.out_pc, 32'h204);
    tick();
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD1_BAD1;
    mid();
    check("t6_flush_valid", bus.out_valid, 0);
    tick();
    bus.flush = 1'b0; bus.imem_rdata = 32'hBAD2_BAD2; bus.pc_valid = 1'b1; bus.pc_in = 32'h300;
    mid();
    check("t6_refill_ready", bus.pc_ready, 1);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rdata = 32'hCAFE_0013;
    tick();
    bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("t6_valid", bus.out_valid, 1);
    check("t6_pc", bus.out_pc, 32'h300);
    check("t6_instr", bus.out_instr, 32'hCAFE_0013);
    tick();
    idle();
    mid();
    check("t6_empty", bus.out_valid, 0);
    tick();

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC is accepted without a memory read and stays in order
    bus.pc_valid = 1'b1; bus.pc_in = 32'h4; bus.imem_gnt = 1'b1;
    tick();
    bus.pc_in = 32'h6; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0111;
    mid();
    check("m_misalign_req", bus.imem_req, 0);
    check("m_misalign_ready", bus.pc_ready, 1);
    tick();
    bus.pc_in = 32'h8; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.out_ready = 1'b1;
    mid();
    check("m_pc0", bus.out_pc, 32'h4);
    check("m_err0", bus.out_err, 0);
    check("m_instr0", bus.out_instr, 32'h0000_0111);
    tick();
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0333;
    mid();
    check("m_pc1", bus.out_pc, 32'h6);
    check("m_err1", bus.out_err, 1);
    check("m_instr1", bus.out_instr, 32'h0000_0013);
    tick();
    bus.imem_rvalid = 1'b0;
    mid();
    check("m_pc2", bus.out_pc, 32'h8);
    check("m_err2", bus.out_err, 0);
    check("m_instr2", bus.out_instr, 32'h0000_0333);
    tick();
    idle();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue that consumes program-counter values from the PC generator and turns them into in-order instruction-memory reads. Fetched instructions are handed to decode together with their PC. Each accepted PC reserves a queue slot at issue, so responses are returned strictly in order. A flush from the branch/jump resolution logic discards queued entries and in-flight responses.

## Interface
- PC_WIDTH, 32, PC/address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue slots; power of two, ≥2

- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- pc_valid  in  1  PC generator offers pc_in
- pc_ready  out  1  PC accepted this cycle when pc_valid & pc_ready
- pc_in  in  PC_WIDTH  fetch address
- flush  in  1  discard all queued and in-flight fetches
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_WIDTH  request address, equals pc_in
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; responses in request order, ≥1 cycle after grant
- imem_rdata  in  INSTR_WIDTH  read data
- out_valid  out  1  head instruction available to decode
- out_ready  in  1  decode consumes head
- out_pc  out  PC_WIDTH  PC of head entry
- out_instr  out  INSTR_WIDTH  instruction of head entry
- out_err  out  1  head entry is a misaligned-fetch error

## Operation
- Slot state: pc, instr, err, filled. Pointers: alloc (tail), fill, head. Counters: count (allocated slots, 0..DEPTH), discard (responses to drop, 0..DEPTH).
- space = (count + discard) < DEPTH. This bounds outstanding reads to DEPTH.
- imem_req = pc_valid & space & !flush & !rst & aligned. The term aligned is always 1 without the macro.
- pc_ready = space & !flush & !rst & (imem_gnt | misaligned).
- An accepted PC allocates the slot at alloc, stores pc, clears filled, and increments alloc.
- On imem_rvalid with discard = 0: the slot at fill takes imem_rdata, is marked filled, and fill increments.
- On imem_rvalid with discard > 0: the data is dropped and discard decrements.
- out_valid = head slot filled & !flush. A pop on out_valid & out_ready frees the slot and increments head.
- Allocate, fill and pop can all occur in the same cycle. count updates by +alloc −pop.
- Flush cycle:
  - count, head, fill and alloc are set to 0.
  - discard is set to (current discard + responses still in flight) − (imem_rvalid this cycle).
  - Nothing is accepted or popped.
- imem_rvalid with no outstanding request is a protocol violation; the bench asserts it never occurs.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: out_valid=0, pc_ready=0, imem_req=0 during rst. count, discard and all pointers are 0. out_pc, out_instr and out_err are 0.
- Minimum latency:
  - PC accepted and granted at cycle T.
  - imem_rvalid at T+1.
  - out_valid at T+2.
- Throughput: one PC per cycle with continuous grant and out_ready.
- pc_ready depends combinationally on imem_gnt and on pc_in[1:0]. imem_req must not depend on pc_ready.
- With imem_gnt=0, imem_req and imem_addr stay stable while pc_in is held.
- Reset mid-operation: the memory side shares rst, so no responses arrive after reset.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A PC with pc_in[1:0] ≠ 0 is accepted without imem_req.
  - Its slot is filled immediately with instr = 32'h00000013 and err = 1.
  - It is not counted as in-flight, and order relative to earlier entries is preserved.
- Undefined:
  - All PCs are issued unmodified.
  - out_err is tied to 0.

## Test plan
- Reset, then pc 0x0/0x4/0x8 with grant, rdata 0x00500093/0x00A00113/0x002081B3 one cycle later → out_valid from cycle T+2, out_pc/out_instr in order, one per cycle.
- out_ready=0, DEPTH=4: four PCs accepted, 5th sees pc_ready=0. One pop → pc_ready=1 the next cycle.
- Two reads outstanding, flush → both responses dropped (discard 2→0). pc 0x100 with rdata 0x00000073 → out_pc=0x100.
- imem_gnt=0 for 3 cycles → pc_ready=0, imem_req=1, imem_addr=0x20 stable. Grant on 4th cycle → accepted once.
- Macro on: pc 0x4, 0x6, 0x8 → 0x6 produces no imem_req. Outputs are 0x4 (err 0), 0x6 (err 1, instr 0x13), 0x8 (err 0), in order.
- Full queue with simultaneous pop and push at count=DEPTH−1, plus rvalid in the flush cycle → count stays constant, and the flush-cycle response is not double-discarded.
